// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS core / memory-bus sequencer.
//   arb_state_t : sequencer state encoding
//   BYTEEN_ALL  : byte-enable driven on every bus access (word accesses only)
//   bus_req_t   : one cycle of bus request as seen on the Avalon master side
//   word_align  : clears the two byte-offset bits of an address
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    COMMIT,
    FAULT
  } arb_state_t;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  typedef struct packed {
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_cpu_mem_arbiter_if.sv
// Avalon-style single-port memory bus between the sequencer and memory.
//   master : sequencer side (drives address/strobes/data, sees stall + rdata)
//   slave  : memory side
interface mips_cpu_mem_arbiter_if;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    input  mem_waitrequest, mem_readdata
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    output mem_waitrequest, mem_readdata
  );

endinterface

// File: rtl/mips_cpu_wait_timer.sv
// Counts consecutive stalled cycles of one bus access.
//   clk, reset : clock, synchronous active-low reset
//   clear      : restart the count (new bus phase); wins over tick
//   tick       : a stalled cycle (strobe high with waitrequest high)
//   expired    : this tick is the TIMEOUT-th stalled cycle of the access;
//                never asserted when TIMEOUT == 0
module mips_cpu_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // count value during the last tolerated stall cycle
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (tick && (cnt_q != '1)) // saturate so a disabled check never wraps
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Expiry is flagged on the stalled cycle that brings the count to TIMEOUT,
  // so the sequencer's next state is FAULT at that same edge.
  assign expired = (TIMEOUT != 0) && tick && (cnt_q >= LAST);

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Sequencer sharing one single-port memory between the fetch and data ports
// of the Harvard MIPS core. Per instruction: fetch the word, hold it for the
// core, perform the core's data access (if any), then pulse cpu_clk_enable
// for one cycle so the core commits.
//   clk, reset          : clock, synchronous active-low reset
//   cpu_active          : core is running; starts each fetch from IDLE
//   cpu_instr_address   : fetch address      -> cpu_instr_readdata (latched)
//   cpu_data_*          : core data request  -> cpu_data_readdata  (latched)
//   cpu_clk_enable      : one-cycle commit strobe
//   mem                 : Avalon master side of the shared memory bus
//   fault               : sticky; bus timeout or read+write requested together
//   retired             : committed instruction count (wraps)
module mips_cpu_mem_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  mips_cpu_mem_arbiter_if.master mem,
  output logic        fault,
  output logic [31:0] retired
);

  arb_state_t  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] retired_q, retired_d;
  logic        clk_en_q, clk_en_d;
  logic        fault_q, fault_d;

  bus_req_t    req;
  logic        data_req;
  logic        data_conflict;
  logic        timer_clear;
  logic        timer_tick;
  logic        timer_expired;

  assign data_req      = cpu_data_read ^ cpu_data_write;
  assign data_conflict = cpu_data_read & cpu_data_write;

  // Stall cycles are counted only while a strobe is actually on the bus.
  // Kept separate from the main decode so the timer feeds it without a loop.
  assign timer_tick = mem.mem_waitrequest &&
                      ((state_q == FETCH) || ((state_q == EXEC) && data_req));

  // Any state change starts a fresh phase, which is what restarts the count
  // on entry to FETCH and to EXEC.
  assign timer_clear = (state_d != state_q);

  mips_cpu_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  // Bus request is decoded from the current state. In EXEC it follows the
  // core's data request combinationally so a zero-wait load/store completes
  // inside EXEC; the core holds those inputs stable because it cannot commit
  // until cpu_clk_enable, which keeps the bus steady across stalls.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    rdata_d   = rdata_q;
    retired_d = retired_q;
    req       = '0;

    case (state_q)
      IDLE: begin
        if (cpu_active) state_d = FETCH;
      end

      FETCH: begin
        req.addr = word_align(cpu_instr_address);
        req.read = 1'b1;
        if (!mem.mem_waitrequest) begin
          instr_d = mem.mem_readdata;
          state_d = EXEC;
        end else if (timer_expired) begin
          state_d = FAULT;
        end
      end

      EXEC: begin
        if (data_conflict) begin
          // strobes stay low; the request is illegal
          state_d = FAULT;
        end else if (data_req) begin
          req.addr  = word_align(cpu_data_address);
          req.read  = cpu_data_read;
          req.write = cpu_data_write;
          req.wdata = cpu_data_writedata;
          if (!mem.mem_waitrequest) begin
            if (cpu_data_read) rdata_d = mem.mem_readdata;
            state_d = COMMIT;
          end else if (timer_expired) begin
            state_d = FAULT;
          end
        end else begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        // the core commits at the edge ending this cycle
        retired_d = retired_q + 32'd1;
        state_d   = IDLE;
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    clk_en_d = (state_d == COMMIT);
    fault_d  = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      rdata_q   <= '0;
      retired_q <= '0;
      clk_en_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
      retired_q <= retired_d;
      clk_en_q  <= clk_en_d;
      fault_q   <= fault_d;
    end
  end

  assign mem.mem_address    = req.addr;
  assign mem.mem_read       = req.read;
  assign mem.mem_write      = req.write;
  assign mem.mem_writedata  = req.wdata;
  assign mem.mem_byteenable = BYTEEN_ALL;

  assign cpu_instr_readdata = instr_q;
  assign cpu_data_readdata  = rdata_q;
  assign cpu_clk_enable     = clk_en_q;
  assign fault              = fault_q;
  assign retired            = retired_q;

endmodule
